gps_spi_packer: RTL and testbench

- Sits downstream of the GPS sample synchronizers and the 4.092 MHz edge detector, in the MCU_CLK_25_000 domain.
- On each sample strobe, captures one GPS sample and packs consecutive samples into 16-bit words.
- Buffers the words in a small FIFO and shifts them out to the MCU as an SPI mode-0 master, MSB first, one word per slave-select frame.
- Reports FIFO occupancy and overflow.

---
 rtl/gps_bridge_pkg.sv | 20 ++
 rtl/gps_word_fifo.sv | 54 +++++
 rtl/gps_spi_packer.sv | 186 ++++++++++++++++++
 tb/tb_gps_spi_packer.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gps_bridge_pkg.sv
// Shared types and defaults for the GPS sample to MCU SPI bridge.
// The SPI state encoding and the packing ratio helper live here so every bridge file agrees on them.
package gps_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    GAP   = 2'd3
  } spi_state_e;

  localparam int DEF_WORD_BITS = 16;
  localparam int DEF_SCK_HALF  = 1;
  localparam int DEF_SS_GAP    = 2;

  function automatic int samples_per_word(input int word_bits, input int sample_bits);
    return word_bits / sample_bits;
  endfunction

endpackage

// File: rtl/gps_word_fifo.sv
// Word FIFO between the sample packer and the SPI shifter.
// A push into a full FIFO is accepted only when a pop happens on the same edge.
module gps_word_fifo #(
  parameter int WORD_BITS  = 16,
  parameter int FIFO_DEPTH = 4,
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1,
  localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 push_i,
  input  logic [WORD_BITS-1:0] din_i,
  input  logic                 pop_i,
  output logic [WORD_BITS-1:0] dout_o,
  output logic                 full_o,
  output logic                 empty_o,
  output logic [LW-1:0]        level_o
);

  logic [WORD_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_q, rd_q;
  logic [LW-1:0]        level_q;
  logic                 do_push, do_pop;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == LW'(FIFO_DEPTH));
  assign level_o = level_q;
  assign dout_o  = mem_q[rd_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // Storage is pure data; only the pointers and level need reset.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end

endmodule

// File: rtl/gps_spi_packer.sv
// Packs strobed GPS samples into words and ships them to the MCU as an SPI mode-0 master.
// All MCU-facing outputs come straight from flops; FIFO drops are reported as a sticky flag plus a count.
module gps_spi_packer
  import gps_bridge_pkg::*;
#(
  parameter int SAMPLE_BITS = 2,
  parameter int WORD_BITS   = DEF_WORD_BITS,
  parameter int FIFO_DEPTH  = 4,
  parameter int SCK_HALF    = DEF_SCK_HALF,
  parameter int SS_GAP      = DEF_SS_GAP
) (
  input  logic                          MCU_CLK_25_000,
  input  logic                          RESET,
  input  logic                          SAMPLE_STROBE,
  input  logic [SAMPLE_BITS-1:0]        SAMPLE_IN,
  output logic                          MCU_SCK,
  output logic                          MCU_SS,
  output logic                          MCU_MOSI,
  output logic [$clog2(FIFO_DEPTH):0]   FIFO_LEVEL,
  output logic                          OVERFLOW,
  output logic [7:0]                    DROP_COUNT
);

  localparam int N  = samples_per_word(WORD_BITS, SAMPLE_BITS);
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int BW = $clog2(WORD_BITS);
  localparam int HW = (SCK_HALF > 1) ? $clog2(SCK_HALF) : 1;
  localparam int GW = (SS_GAP > 1) ? $clog2(SS_GAP) : 1;

  logic [CW-1:0]        cnt_q, cnt_d;
  logic [WORD_BITS-1:0] pk_q, pk_d;
  logic                 push;

  logic [WORD_BITS-1:0] fifo_dout;
  logic                 fifo_full, fifo_empty;
  logic                 pop, drop;

  spi_state_e           state_q, state_d;
  logic [WORD_BITS-1:0] sh_q, sh_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic                 ph_q, ph_d;
  logic [HW-1:0]        hc_q, hc_d;
  logic [GW-1:0]        gc_q, gc_d;
  logic                 half_done;
  logic                 sck_d, ss_d, mosi_d;

  // First sample of a word ends in the MSBs; the Nth strobe pushes on its own edge.
  always_comb begin
    cnt_d = cnt_q;
    pk_d  = pk_q;
    push  = 1'b0;
    if (SAMPLE_STROBE) begin
      pk_d = {pk_q[WORD_BITS-SAMPLE_BITS-1:0], SAMPLE_IN};
      if (cnt_q == CW'(N - 1)) begin
        cnt_d = '0;
        push  = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  gps_word_fifo #(
    .WORD_BITS (WORD_BITS),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (MCU_CLK_25_000),
    .rst_i  (RESET),
    .push_i (push),
    .din_i  (pk_d),
    .pop_i  (pop),
    .dout_o (fifo_dout),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .level_o(FIFO_LEVEL)
  );

  assign drop      = push && fifo_full && !pop;
  assign half_done = (hc_q == HW'(SCK_HALF - 1));

  always_ff @(posedge MCU_CLK_25_000 or posedge RESET) begin
    if (RESET) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    bit_d   = bit_q;
    ph_d    = ph_q;
    hc_d    = hc_q;
    gc_d    = gc_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          sh_d    = fifo_dout;
          state_d = SETUP;
        end
      end
      SETUP: begin
        bit_d   = BW'(WORD_BITS - 1);
        ph_d    = 1'b0;
        hc_d    = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        if (!half_done) begin
          hc_d = hc_q + HW'(1);
        end else begin
          hc_d = '0;
          if (!ph_q) begin
            ph_d = 1'b1;
          end else if (bit_q == '0) begin
            gc_d    = '0;
            state_d = GAP;
          end else begin
            ph_d  = 1'b0;
            bit_d = bit_q - BW'(1);
            sh_d  = {sh_q[WORD_BITS-2:0], 1'b0};
          end
        end
      end
      GAP: begin
        if (gc_q == GW'(SS_GAP - 1)) state_d = IDLE;
        else                         gc_d    = gc_q + GW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // Low phase already presents the next bit, so MOSI moves on the falling SCK edge.
  always_comb begin
    sck_d  = 1'b0;
    ss_d   = 1'b1;
    mosi_d = 1'b0;
    case (state_q)
      SETUP: begin
        ss_d   = 1'b0;
        mosi_d = sh_q[WORD_BITS-1];
      end
      SHIFT: begin
        ss_d   = 1'b0;
        sck_d  = !ph_q;
        mosi_d = ph_q ? sh_q[WORD_BITS-2] : sh_q[WORD_BITS-1];
      end
      default: ;
    endcase
  end

  always_ff @(posedge MCU_CLK_25_000 or posedge RESET) begin
    if (RESET) begin
      cnt_q      <= '0;
      pk_q       <= '0;
      bit_q      <= '0;
      ph_q       <= 1'b0;
      hc_q       <= '0;
      gc_q       <= '0;
      MCU_SCK    <= 1'b0;
      MCU_SS     <= 1'b1;
      MCU_MOSI   <= 1'b0;
      OVERFLOW   <= 1'b0;
      DROP_COUNT <= '0;
    end else begin
      cnt_q    <= cnt_d;
      pk_q     <= pk_d;
      bit_q    <= bit_d;
      ph_q     <= ph_d;
      hc_q     <= hc_d;
      gc_q     <= gc_d;
      MCU_SCK  <= sck_d;
      MCU_SS   <= ss_d;
      MCU_MOSI <= mosi_d;
      if (drop) begin
        OVERFLOW <= 1'b1;
        if (DROP_COUNT != 8'hFF) DROP_COUNT <= DROP_COUNT + 8'd1;
      end
    end
  end

  always_ff @(posedge MCU_CLK_25_000) begin
    sh_q <= sh_d;
  end

endmodule

// File: tb/tb_gps_spi_packer.sv
// Bench for gps_spi_packer: a cycle-level reference model fills a scoreboard of words
// as stimulus is driven; a pin-level SPI monitor decodes frames and compares against it.
module tb_gps_spi_packer;

  localparam int SB        = 2;
  localparam int WB        = 16;
  localparam int FD        = 4;
  localparam int NS        = WB / SB;
  localparam int BUSY_CYC  = 35;
  localparam int DRAIN_MAX = 3000;

  logic          clk    = 1'b0;
  logic          rst    = 1'b1;
  logic          strobe = 1'b0;
  logic [SB-1:0] sin    = '0;
  logic          sck, ss, mosi, ovf;
  logic [2:0]    lvl;
  logic [7:0]    drops;

  gps_spi_packer #(
    .SAMPLE_BITS(SB),
    .WORD_BITS  (WB),
    .FIFO_DEPTH (FD),
    .SCK_HALF   (1),
    .SS_GAP     (2)
  ) dut (
    .MCU_CLK_25_000(clk),
    .RESET         (rst),
    .SAMPLE_STROBE (strobe),
    .SAMPLE_IN     (sin),
    .MCU_SCK       (sck),
    .MCU_SS        (ss),
    .MCU_MOSI      (mosi),
    .FIFO_LEVEL    (lvl),
    .OVERFLOW      (ovf),
    .DROP_COUNT    (drops)
  );

  always #20 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model
  logic [WB-1:0] m_fifo[$];
  logic [WB-1:0] sb[$];
  int            m_cnt   = 0;
  logic [WB-1:0] m_sh    = '0;
  int            m_busy  = 0;
  int            m_drops = 0;
  int            m_pops  = 0;
  bit            m_ovf   = 1'b0;
  int            last_strobe_edge = 0;

  task automatic model_reset();
    m_fifo.delete();
    sb.delete();
    m_cnt  = 0;
    m_sh   = '0;
    m_busy = 0;
    m_drops = 0;
    m_ovf  = 1'b0;
  endtask

  task automatic model_step(input bit stb, input logic [SB-1:0] s);
    bit            do_pop;
    bit            do_push;
    logic [WB-1:0] w;
    do_pop  = 1'b0;
    do_push = 1'b0;
    w       = m_sh;
    if (m_busy > 0) m_busy--;
    else if (m_fifo.size() > 0) do_pop = 1'b1;
    if (stb) begin
      w    = {m_sh[WB-SB-1:0], s};
      m_sh = w;
      if (m_cnt == NS - 1) begin
        do_push = 1'b1;
        m_cnt   = 0;
      end else begin
        m_cnt++;
      end
    end
    if (do_pop) begin
      sb.push_back(m_fifo.pop_front());
      m_busy = BUSY_CYC;
      m_pops++;
    end
    if (do_push) begin
      if (m_fifo.size() < FD) m_fifo.push_back(w);
      else begin
        m_ovf = 1'b1;
        if (m_drops < 255) m_drops++;
      end
    end
  endtask

  task automatic tick(input bit stb, input logic [SB-1:0] s);
    @(negedge clk);
    strobe = stb;
    sin    = s;
    if (stb) last_strobe_edge = cyc + 1;
    model_step(stb, s);
  endtask

  // SPI monitor
  bit            mon_in_frame = 1'b0;
  bit            mon_prev_ss  = 1'b1;
  bit            mon_prev_sck = 1'b0;
  int            mon_nbits    = 0;
  int            mon_ss_low   = 0;
  int            mon_frames   = 0;
  int            mon_ss_fall  = 0;
  int            lvl_max      = 0;
  int            ovf_low_cnt  = 0;
  logic [WB-1:0] mon_word     = '0;
  logic [WB-1:0] mon_last     = '0;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        mon_in_frame = 1'b0;
        mon_prev_ss  = 1'b1;
        mon_prev_sck = 1'b0;
        mon_nbits    = 0;
      end else begin
        if (int'(lvl) > lvl_max) lvl_max = int'(lvl);
        if (!ovf) ovf_low_cnt++;
        if (!ss) begin
          if (mon_prev_ss) begin
            mon_in_frame = 1'b1;
            mon_nbits    = 0;
            mon_ss_low   = 0;
            mon_word     = '0;
            mon_ss_fall  = cyc;
          end
          mon_ss_low++;
          if (sck && !mon_prev_sck) begin
            mon_word = {mon_word[WB-2:0], mosi};
            mon_nbits++;
          end
        end else if (!mon_prev_ss && mon_in_frame) begin
          mon_in_frame = 1'b0;
          mon_frames++;
          mon_last = mon_word;
          check_eq("frame_ss_low_cycles", mon_ss_low, 33);
          check_eq("frame_sck_rises", mon_nbits, 16);
          check_eq("frame_expected_present", sb.size() > 0, 1);
          if (sb.size() > 0) check_eq("frame_word", mon_word, sb.pop_front());
        end
        mon_prev_ss  = ss;
        mon_prev_sck = sck;
      end
    end
  end

  task automatic drain();
    int n;
    n = 0;
    while ((m_fifo.size() != 0 || m_busy != 0 || mon_in_frame) && n < DRAIN_MAX) begin
      tick(1'b0, '0);
      n++;
    end
    repeat (4) tick(1'b0, '0);
    check_eq("drain_within_bound", n < DRAIN_MAX, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    strobe = 1'b0;
    rst    = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int            f0, p0, s8, n;
    logic [WB-1:0] exp_w;
    logic [SB-1:0] s;

    // Reset state
    model_reset();
    repeat (3) @(negedge clk);
    check_eq("rst_sck", sck, 0);
    check_eq("rst_ss", ss, 1);
    check_eq("rst_mosi", mosi, 0);
    check_eq("rst_level", lvl, 0);
    check_eq("rst_overflow", ovf, 0);
    check_eq("rst_drops", drops, 0);
    rst = 1'b0;

    // Single word, spaced strobes
    f0 = mon_frames;
    for (int i = 0; i < NS; i++) begin
      tick(1'b1, SB'(3 - (i % 4)));
      repeat (5) tick(1'b0, '0);
    end
    s8 = last_strobe_edge;
    drain();
    check_eq("t1_frame_count", mon_frames - f0, 1);
    check_eq("t1_word", mon_last, 32'hE4E4);
    check_eq("t1_ss_latency", mon_ss_fall - s8, 2);

    // Steady stream, 100 words
    f0 = mon_frames;
    lvl_max = 0;
    for (int i = 0; i < 800; i++) begin
      tick(1'b1, SB'(i + i / 8));
      repeat (5) tick(1'b0, '0);
    end
    drain();
    check_eq("t2_frame_count", mon_frames - f0, 100);
    check_eq("t2_level_le1", lvl_max <= 1, 1);
    check_eq("t2_overflow", ovf, 0);

    // Back-to-back burst overflows the FIFO
    f0 = mon_frames;
    p0 = m_pops;
    lvl_max = 0;
    for (int i = 0; i < 64; i++) tick(1'b1, SB'($urandom_range(0, 3)));
    tick(1'b0, '0);
    drain();
    check_eq("t3_frame_count", mon_frames - f0, m_pops - p0);
    check_eq("t3_overflow", ovf, 1);
    check_eq("t3_overflow_model", ovf, m_ovf);
    check_eq("t3_drops", drops, m_drops);
    check_eq("t3_level_peak", lvl_max, 4);

    // Long overload saturates the drop counter
    ovf_low_cnt = 0;
    for (int i = 0; i < 400 * NS; i++) tick(1'b1, SB'($urandom_range(0, 3)));
    tick(1'b0, '0);
    check_eq("t4_drops_saturated", drops, 255);
    check_eq("t4_drops_model", drops, m_drops);
    check_eq("t4_overflow_sticky", ovf_low_cnt, 0);

    // Asynchronous reset in the middle of a frame
    do_reset();
    check_eq("t5_overflow_cleared", ovf, 0);
    check_eq("t5_drops_cleared", drops, 0);
    for (int i = 0; i < 2 * NS; i++) tick(1'b1, SB'($urandom_range(0, 3)));
    n = 0;
    while (!(mon_in_frame && mon_nbits == 9) && n < 200) begin
      tick(1'b0, '0);
      n++;
    end
    check_eq("t5_reached_bit7", n < 200, 1);
    check_eq("t5_level_before_reset", lvl, m_fifo.size());
    @(posedge clk);
    #5;
    rst = 1'b1;
    model_reset();
    #1;
    check_eq("t5_async_sck", sck, 0);
    check_eq("t5_async_ss", ss, 1);
    check_eq("t5_async_mosi", mosi, 0);
    check_eq("t5_async_level", lvl, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    f0 = mon_frames;
    exp_w = '0;
    for (int i = 0; i < NS; i++) begin
      s = SB'(i + 1);
      exp_w = {exp_w[WB-SB-1:0], s};
      tick(1'b1, s);
      repeat (5) tick(1'b0, '0);
    end
    drain();
    check_eq("t5_frame_count", mon_frames - f0, 1);
    check_eq("t5_fresh_word", mon_last, exp_w);

    // Push coinciding with a pop while full
    do_reset();
    f0 = mon_frames;
    for (int i = 0; i < 6 * NS + NS - 1; i++) tick(1'b1, SB'(i + i / 8));
    n = 0;
    while (!(m_busy == 0 && m_fifo.size() == FD) && n < 200) begin
      tick(1'b0, '0);
      n++;
    end
    check_eq("t6_full_at_pop", n < 200, 1);
    check_eq("t6_level_full", lvl, 4);
    tick(1'b1, 2'd3);
    tick(1'b0, '0);
    check_eq("t6_level_after", lvl, 4);
    drain();
    check_eq("t6_drops", drops, 0);
    check_eq("t6_overflow", ovf, 0);
    check_eq("t6_frame_count", mon_frames - f0, 7);
    check_eq("scoreboard_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
